sdram_probe_clear: RTL

- Parametrised successor to the fixed 3-point SDRAM size probe used by the menu core.
- After power-up it detects the installed SDRAM size by writing a signature to each of NPROBE power-of-two probe addresses, then reading them back.
- It then optionally clears the detected region, paced so the clear never starves other users.
- It sits between clk_sys logic and the sdram controller's single-word rd/we/ready port; its size mask feeds hps_io status_menumask.

---
 rtl/sdram_probe_clear_pkg.sv | 36 +++
 rtl/sdram_probe_clear_seq.sv | 76 +++++++
 rtl/sdram_probe_clear.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_probe_clear_pkg.sv
// Shared types and helpers for the SDRAM size probe / clear block.
// Optional clear sweep is enabled by defining SDRAM_PROBE_CLEAR_EN.
package sdram_probe_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_WR_SIG,
        ST_WR_SCRUB,
        ST_RD_SIG,
        ST_EVAL,
        ST_CLEAR,
        ST_DONE
    } probe_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_GAP,
        SEQ_WAIT
    } seq_state_e;

    // Written to the scrub address between signature writes and reads.
    localparam int unsigned SCRUB_DATA = 12345;

    // Signature for probe point i; caller truncates to the data width.
    function automatic logic [31:0] sig(input int unsigned i, input int unsigned base);
        return base * (i + 1);
    endfunction

    // Probe address i: 0 for the first point, then successive powers of two.
    function automatic logic [63:0] probe_addr(input int unsigned i, input int unsigned first_log2);
        if (i == 0) return '0;
        return 64'd1 << (first_log2 + i - 1);
    endfunction

endpackage

// File: rtl/sdram_probe_clear_seq.sv
// Single-access handshake sequencer: issue one request cycle, skip one GAP
// cycle, then wait for i_mem_ready. Shared by the probe and clear phases.
module mem_access_seq
    import sdram_probe_pkg::*;
#(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic              i_is_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_busy,
    output logic              o_cpl,
    output logic              o_rdata_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_mem_we,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_ready
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              w_accept;

    assign w_accept = (r_state == SEQ_IDLE) && i_go && i_mem_ready;

    // State register; reset aborts any access in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= SEQ_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Latch the request so addr/din stay stable until the next one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else if (w_accept) begin
            r_is_wr <= i_is_wr;
            r_addr  <= i_addr;
            r_din   <= i_din;
        end
    end

    // Next-state: ready is ignored during the GAP cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE:  if (i_go && i_mem_ready) w_state_nxt = SEQ_ISSUE;
            SEQ_ISSUE: w_state_nxt = SEQ_GAP;
            SEQ_GAP:   w_state_nxt = SEQ_WAIT;
            SEQ_WAIT:  if (i_mem_ready) w_state_nxt = SEQ_IDLE;
            default:   w_state_nxt = SEQ_IDLE;
        endcase
    end

    assign o_mem_we      = (r_state == SEQ_ISSUE) &&  r_is_wr;
    assign o_mem_rd      = (r_state == SEQ_ISSUE) && !r_is_wr;
    assign o_mem_addr    = r_addr;
    assign o_mem_din     = r_din;
    assign o_busy        = (r_state != SEQ_IDLE);
    assign o_cpl         = (r_state == SEQ_WAIT) && i_mem_ready;
    assign o_rdata_valid = o_cpl && !r_is_wr;
    assign o_rdata       = i_mem_dout;

endmodule

// File: rtl/sdram_probe_clear.sv
// SDRAM size probe with optional paced clear of the detected region.
// Define SDRAM_PROBE_CLEAR_EN to build the clear sweep; otherwise EVAL goes
// straight to DONE and clear_busy is tied low.
module sdram_probe_clear
    import sdram_probe_pkg::*;
#(
    parameter int unsigned ADDR_W      = 27,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NPROBE      = 3,
    parameter int unsigned PROBE_LOG2  = 25,
    parameter int unsigned SIG_BASE    = 1032,
    parameter int unsigned CLEAR_GAP   = 32,
    parameter int unsigned CLEAR_VALUE = 0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic [NPROBE-1:0] size_mask,
    output logic              size_valid,
    output logic              size_err,
    output logic              clear_busy,
    output logic              done
);

    localparam int unsigned       IDX_W    = (NPROBE > 1) ? $clog2(NPROBE) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NPROBE - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] A_SCRUB  = ADDR_W'(64'd1 << (PROBE_LOG2 - 1));

    if (NPROBE < 1 || NPROBE > 8) begin : g_bad_nprobe
        $error("sdram_probe_clear: NPROBE must be 1..8");
    end
    if (PROBE_LOG2 < 1 || ADDR_W < PROBE_LOG2 + NPROBE - 1) begin : g_bad_addr
        $error("sdram_probe_clear: PROBE_LOG2/ADDR_W out of range");
    end
    if (CLEAR_GAP < 2) begin : g_bad_gap
        $error("sdram_probe_clear: CLEAR_GAP must be >= 2");
    end
    if (DATA_W < 32 && CLEAR_VALUE >= (1 << DATA_W)) begin : g_bad_cval
        $error("sdram_probe_clear: CLEAR_VALUE does not fit DATA_W");
    end

    probe_state_e      r_state;
    probe_state_e      w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [NPROBE-1:0] r_mask;
    logic              r_valid;
    logic              r_err;

    logic              w_go;
    logic              w_is_wr;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_busy;
    logic              w_cpl;
    logic              w_rdata_valid;
    logic [DATA_W-1:0] w_rdata;
    logic              w_last_idx;
    logic [DATA_W-1:0] w_sig_cur;
    logic [ADDR_W-1:0] w_probe_addr;

    assign w_last_idx   = (r_idx == '0);
    assign w_sig_cur    = DATA_W'(sig(32'(r_idx), SIG_BASE));
    assign w_probe_addr = ADDR_W'(probe_addr(32'(r_idx), PROBE_LOG2));

    mem_access_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq (
        .i_clk         (clk_sys),
        .i_rst_n       (reset_n),
        .i_go          (w_go),
        .i_is_wr       (w_is_wr),
        .i_addr        (w_addr),
        .i_din         (w_din),
        .o_busy        (w_busy),
        .o_cpl         (w_cpl),
        .o_rdata_valid (w_rdata_valid),
        .o_rdata       (w_rdata),
        .o_mem_addr    (mem_addr),
        .o_mem_din     (mem_din),
        .o_mem_we      (mem_we),
        .o_mem_rd      (mem_rd),
        .i_mem_dout    (mem_dout),
        .i_mem_ready   (mem_ready)
    );

`ifdef SDRAM_PROBE_CLEAR_EN
    localparam int unsigned       GAP_W   = $clog2(CLEAR_GAP + 1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE = GAP_W'(1);

    // Counter is one bit wider than the address so L = 2^ADDR_W terminates.
    logic [ADDR_W:0]  r_clr_cnt;
    logic [ADDR_W:0]  r_clr_lim;
    logic [ADDR_W:0]  w_clr_lim;
    logic [ADDR_W:0]  w_clr_next;
    logic [GAP_W-1:0] r_gap;
    logic             w_run;
    int unsigned      w_k;

    assign w_clr_next = r_clr_cnt + CNT_ONE;

    // Clear limit from the contiguous low prefix of the mask only.
    always_comb begin
        w_k   = 0;
        w_run = r_mask[0];
        for (int unsigned i = 1; i < NPROBE; i++) begin
            w_run = w_run & r_mask[i];
            if (w_run) w_k = i;
        end
        w_clr_lim = CNT_ONE << (PROBE_LOG2 + w_k);
    end

    // Clear address counter and request pacing countdown.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_clr_cnt <= '0;
            r_clr_lim <= '0;
            r_gap     <= '0;
        end else if (r_state == ST_EVAL) begin
            r_clr_cnt <= '0;
            r_clr_lim <= w_clr_lim;
            r_gap     <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (w_go && mem_ready)  r_gap <= GAP_W'(CLEAR_GAP - 1);
            else if (r_gap != '0)   r_gap <= r_gap - GAP_ONE;
            if (w_cpl) r_clr_cnt <= w_clr_next;
        end
    end

    assign clear_busy = (r_state == ST_CLEAR);
`else
    assign clear_busy = 1'b0;
`endif

    // Main state register.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_state <= ST_WAIT_INIT;
        else          r_state <= w_state_nxt;
    end

    // Next-state and request generation; one access per probe step.
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_is_wr     = 1'b1;
        w_addr      = '0;
        w_din       = '0;
        case (r_state)
            ST_WAIT_INIT: if (mem_ready) w_state_nxt = ST_WR_SIG;
            ST_WR_SIG: begin
                w_go   = !w_busy;
                w_addr = w_probe_addr;
                w_din  = w_sig_cur;
                if (w_cpl && w_last_idx) w_state_nxt = ST_WR_SCRUB;
            end
            ST_WR_SCRUB: begin
                w_go   = !w_busy;
                w_addr = A_SCRUB;
                w_din  = DATA_W'(SCRUB_DATA);
                if (w_cpl) w_state_nxt = ST_RD_SIG;
            end
            ST_RD_SIG: begin
                w_go    = !w_busy;
                w_is_wr = 1'b0;
                w_addr  = w_probe_addr;
                if (w_rdata_valid && w_last_idx) w_state_nxt = ST_EVAL;
            end
`ifdef SDRAM_PROBE_CLEAR_EN
            ST_EVAL: w_state_nxt = r_mask[0] ? ST_CLEAR : ST_DONE;
            ST_CLEAR: begin
                w_go   = !w_busy && (r_gap == '0);
                w_addr = r_clr_cnt[ADDR_W-1:0];
                w_din  = DATA_W'(CLEAR_VALUE);
                if (w_cpl && (w_clr_next == r_clr_lim)) w_state_nxt = ST_DONE;
            end
`else
            ST_EVAL: w_state_nxt = ST_DONE;
`endif
            ST_DONE: if (start) w_state_nxt = ST_WAIT_INIT;
            default: w_state_nxt = ST_WAIT_INIT;
        endcase
    end

    // Probe index, result mask and status flags.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_idx   <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_INIT: begin
                    r_idx  <= IDX_LAST;
                    r_mask <= '0;
                end
                ST_WR_SIG: if (w_cpl) r_idx <= w_last_idx ? IDX_LAST : r_idx - IDX_ONE;
                ST_RD_SIG: if (w_rdata_valid) begin
                    r_mask[r_idx] <= (w_rdata == w_sig_cur);
                    if (!w_last_idx) r_idx <= r_idx - IDX_ONE;
                end
                ST_EVAL: begin
                    r_valid <= 1'b1;
                    r_err   <= ~r_mask[0];
                end
                ST_DONE: if (start) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign size_mask  = r_mask;
    assign size_valid = r_valid;
    assign size_err   = r_err;
    assign done       = (r_state == ST_DONE);

endmodule
